muldiv_ctrl: RTL and testbench

Sequencing controller for the shared multiply/divide datapath in the EX stage. Accepts one mult/multu/div/divu request at a time, latches operands, holds them stable on the combinational datapath for a parameterised number of cycles, then commits the result into architectural HI/LO registers. Also services MTHI/MTLO writes and MFHI/MFLO reads, and raises a pipeline stall while an operation is in flight.

---
 rtl/muldiv_ctrl.sv | 111 +++++++++++
 tb/tb_muldiv_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// HI/LO sequencing controller for the shared multiply/divide datapath.
// Optional feature: define MULDIV_DIVZERO_EN to short-circuit divide-by-zero.
module muldiv_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    input  logic        mfhi,
    input  logic        mflo,
    input  logic        flush,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic        div0,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    output logic [1:0]  md_op,
    input  logic [31:0] md_hi,
    input  logic [31:0] md_lo
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    state_t           state;
    logic [31:0]      hi;
    logic [31:0]      lo;
    logic [31:0]      op_a;
    logic [31:0]      op_b;
    logic [1:0]       op_r;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            hi    <= 32'd0;
            lo    <= 32'd0;
            op_a  <= 32'd0;
            op_b  <= 32'd0;
            op_r  <= 2'b00;
            cnt   <= '0;
            done  <= 1'b0;
            div0  <= 1'b0;
        end else begin
            done <= 1'b0;
            div0 <= 1'b0;
            case (state)
                IDLE: begin
                    // A start takes the cycle; any MTHI/MTLO alongside it is dropped.
                    if (start && !flush) begin
                        op_a <= a;
                        op_b <= b;
                        op_r <= op;
`ifdef MULDIV_DIVZERO_EN
                        if (op[1] && (b == 32'd0)) begin
                            hi   <= a;
                            lo   <= 32'hFFFF_FFFF;
                            done <= 1'b1;
                            div0 <= 1'b1;
                        end else begin
                            cnt   <= op[1] ? DIV_CNT : MUL_CNT;
                            state <= RUN;
                        end
`else
                        cnt   <= op[1] ? DIV_CNT : MUL_CNT;
                        state <= RUN;
`endif
                    end else begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                RUN: begin
                    // Squash wins over a commit landing in the same cycle.
                    if (flush) begin
                        state <= IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        hi    <= md_hi;
                        lo    <= md_lo;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign md_a  = op_a;
    assign md_b  = op_b;
    assign md_op = op_r;

    assign busy  = (state == RUN);
    assign stall = busy & (start | mthi | mtlo | mfhi | mflo);
    assign rdata = mfhi ? hi : (mflo ? lo : 32'd0);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomised bench for muldiv_ctrl against a transaction-level HI/LO model
// and an arithmetic stand-in for the multiply/divide datapath.
module tb_muldiv_ctrl;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;
    localparam int CNT_W   = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        mthi, mtlo, mfhi, mflo, flush;
    logic [31:0] rdata;
    logic        busy, stall, done, div0;
    logic [31:0] md_a, md_b, md_hi, md_lo;
    logic [1:0]  md_op;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;
    logic [31:0] exp_q[$];

    muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .mfhi(mfhi), .mflo(mflo),
        .flush(flush), .rdata(rdata), .busy(busy), .stall(stall), .done(done),
        .div0(div0), .md_a(md_a), .md_b(md_b), .md_op(md_op),
        .md_hi(md_hi), .md_lo(md_lo)
    );

    // clock / reset
    always #5 clk = ~clk;

    // MIPS-style result: {HI, LO} = product, or {remainder, quotient}
    function automatic logic [63:0] md_ref(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        logic [31:0] q, r;
        p = 64'd0;
        q = 32'd0;
        r = 32'd0;
        case (o)
            2'b00: p = {{32{x[31]}}, x} * {{32{y[31]}}, y};
            2'b01: p = {32'd0, x} * {32'd0, y};
            2'b10: begin
                if (y == 32'd0) begin
                    q = 32'hFFFF_FFFF; r = x;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    q = 32'h8000_0000; r = 32'd0;
                end else begin
                    q = $signed(x) / $signed(y);
                    r = $signed(x) % $signed(y);
                end
                p = {r, q};
            end
            default: begin
                if (y == 32'd0) begin
                    q = 32'hFFFF_FFFF; r = x;
                end else begin
                    q = x / y;
                    r = x % y;
                end
                p = {r, q};
            end
        endcase
        return p;
    endfunction

    // datapath stand-in driven from the latched operands
    always_comb {md_hi, md_lo} = md_ref(md_op, md_a, md_b);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    endtask

    task automatic clear_reqs();
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0; mfhi = 1'b0; mflo = 1'b0; flush = 1'b0;
    endtask

    // scoreboard read-back through MFHI/MFLO (called at negedge, DUT idle)
    task automatic read_back();
        exp_q.push_back(exp_hi);
        exp_q.push_back(exp_lo);
        exp_q.push_back(exp_hi);
        exp_q.push_back(32'd0);
        mfhi = 1'b1; mflo = 1'b0; #1; check("rd_hi", rdata, exp_q.pop_front());
        mfhi = 1'b0; mflo = 1'b1; #1; check("rd_lo", rdata, exp_q.pop_front());
        mfhi = 1'b1; mflo = 1'b1; #1; check("rd_prio", rdata, exp_q.pop_front());
        mfhi = 1'b0; mflo = 1'b0; #1; check("rd_none", rdata, exp_q.pop_front());
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // MTHI/MTLO in IDLE, optionally with a flush-suppressed start
    task automatic idle_write(input bit hi_en, input bit lo_en, input logic [31:0] data, input bit with_start_flush);
        mthi = hi_en; mtlo = lo_en; wdata = data;
        if (with_start_flush) begin
            start = 1'b1; flush = 1'b1; op = 2'($urandom); a = $urandom; b = $urandom;
        end
        #1 check("idle_stall", stall, 0);
        step();
        clear_reqs();
        if (hi_en) exp_hi = data;
        if (lo_en) exp_lo = data;
        check("wr_busy", busy, 0);
        check("wr_done", done, 0);
        read_back();
    endtask

    // abort_kind: 0 none, 1 flush in busy cycle abort_at, 2 reset in busy cycle abort_at
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int abort_kind, input int abort_at, input bit noise);
        int lat;
        logic [63:0] r;
        bit dz;
        logic any;
        lat = o[1] ? DIV_LAT : MUL_LAT;
        r = md_ref(o, x, y);
        dz = 1'b0;
`ifdef MULDIV_DIVZERO_EN
        dz = o[1] && (y == 32'd0);
        if (dz) r = {x, 32'hFFFF_FFFF};
`endif
        start = 1'b1; op = o; a = x; b = y;
        if (noise) begin
            mthi = 1'($urandom_range(0, 1)); mtlo = 1'($urandom_range(0, 1)); wdata = $urandom;
        end
        step();
        clear_reqs();
        a = $urandom; b = $urandom; op = 2'($urandom);
        if (dz) begin
            exp_hi = r[63:32]; exp_lo = r[31:0];
            check("dz_busy", busy, 0);
            check("dz_done", done, 1);
            check("dz_div0", div0, 1);
            read_back();
            step();
            check("dz_done_pulse", done, 0);
            check("dz_div0_pulse", div0, 0);
            return;
        end
        for (int j = 1; j <= lat; j++) begin
            check("run_busy", busy, 1);
            check("run_done", done, 0);
            check("run_div0", div0, 0);
            check("md_a", md_a, x);
            check("md_b", md_b, y);
            check("md_op", md_op, o);
            if (abort_kind == 1 && j == abort_at) begin
                flush = 1'b1;
                step();
                clear_reqs();
                check("flush_busy", busy, 0);
                check("flush_done", done, 0);
                read_back();
                return;
            end
            if (abort_kind == 2 && j == abort_at) begin
                reset = 1'b1;
                #1;
                exp_hi = 32'd0; exp_lo = 32'd0;
                check("rst_busy", busy, 0);
                check("rst_md_a", md_a, 0);
                #1 reset = 1'b0;
                check("rst_done", done, 0);
                read_back();
                return;
            end
            if (noise) begin
                start = 1'($urandom_range(0, 1)); mthi = 1'($urandom_range(0, 1));
                mtlo  = 1'($urandom_range(0, 1)); mfhi = 1'($urandom_range(0, 1));
                mflo  = 1'($urandom_range(0, 1)); wdata = $urandom;
            end
            #1;
            any = start | mthi | mtlo | mfhi | mflo;
            check("run_stall", stall, any);
            check("run_rdata", rdata, mfhi ? exp_hi : (mflo ? exp_lo : 32'd0));
            step();
            clear_reqs();
        end
        exp_hi = r[63:32]; exp_lo = r[31:0];
        check("commit_busy", busy, 0);
        check("commit_done", done, 1);
        check("commit_div0", div0, 0);
        read_back();
        step();
        check("done_pulse", done, 0);
    endtask

    initial begin
        int o_i, k, lat;
        logic [31:0] x, y;
        reset = 1'b1;
        clear_reqs();
        op = 2'b00; a = 32'd0; b = 32'd0; wdata = 32'd0;
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_div0", div0, 0);
        check("reset_md_a", md_a, 0);
        check("reset_md_b", md_b, 0);
        check("reset_md_op", md_op, 0);
        reset = 1'b0;
        read_back();

        issue(2'b00, 32'hFFFF_FFFD, 32'd7, 0, 0, 1'b0);
        issue(2'b11, 32'd100, 32'd7, 0, 0, 1'b1);
        idle_write(1'b1, 1'b1, 32'h1234_5678, 1'b0);
        idle_write(1'b0, 1'b1, 32'h9ABC_DEF0, 1'b0);
        idle_write(1'b1, 1'b0, 32'h0BAD_F00D, 1'b1);
        issue(2'b10, 32'd1234, 32'd56, 1, 5, 1'b0);
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b1);
        issue(2'b10, 32'hDEAD_BEEF, 32'd3, 2, 7, 1'b0);
        issue(2'b10, 32'd55, 32'd0, 0, 0, 1'b0);
        issue(2'b00, 32'h0001_0003, 32'h7FFF_0001, 1, MUL_LAT, 1'b0);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b0);

        for (int n = 0; n < 30; n++) begin
            o_i = $urandom_range(0, 3);
            x = $urandom;
            y = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            lat = (o_i >= 2) ? DIV_LAT : MUL_LAT;
            k = $urandom_range(0, 7);
            if (k == 0)      issue(2'(o_i), x, y, 1, $urandom_range(1, lat), 1'b1);
            else if (k == 1) issue(2'(o_i), x, y, 2, $urandom_range(1, lat), 1'b1);
            else if (k == 2) idle_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
            else             issue(2'(o_i), x, y, 0, 0, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
